axis_capture_mem: RTL and testbench
===================================

# axis_capture_mem

Multi-channel successor to the single-channel AXI-stream circular capture buffer. Beats are steered by `s_axis_tdest` into one of `NUM_CHANNELS` independent circular regions of a shared inferred RAM. Each channel either runs continuously, overwriting its oldest entry, or captures one frame and freezes until released. It sits between streaming DSP outputs and the host register/readback path, which reads samples by channel and age-relative index.

## Interface
- `DATA_WIDTH`, 32, sample width in bits.
- `MEMORY_DEPTH`, 32, entries per channel; power of two, ≥ 2.
- `NUM_CHANNELS`, 4, channel count; ≥ 1.
- `FRAME_MODE`, 0, 0 = continuous circular, 1 = freeze-on-frame.
- Derived: `AW = log2(MEMORY_DEPTH)`, `CW = max(1, log2(NUM_CHANNELS))`.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-low reset.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tready`  out  1  beat accept.
- `s_axis_tdata`  in  DATA_WIDTH  sample.
- `s_axis_tlast`  in  1  frame/packet end.
- `s_axis_tdest`  in  CW  target channel.
- `release`  in  NUM_CHANNELS  per-channel unfreeze pulse; used only when FRAME_MODE=1.
- `rd_chan`  in  CW  read channel.
- `rd_addr`  in  AW  read index; 0 = oldest stored entry.
- `rd_data`  out  DATA_WIDTH  registered read data.
- `rd_valid`  out  1  registered; 1 when `rd_addr` < stored count of `rd_chan`.
- `rd_count`  out  AW+1  registered stored count of `rd_chan`, range 0..MEMORY_DEPTH.
- `frozen`  out  NUM_CHANNELS  per-channel frozen flag.
- `wrapped`  out  NUM_CHANNELS  sticky; the channel has overwritten at least one entry since its last restart.

## Operation
- Per-channel state: `wr_ptr` (AW bits), `count` (AW+1 bits, saturates at MEMORY_DEPTH), `restart_pending`, `frozen`, `wrapped`.
- RAM address is `{channel, ptr}`. Total RAM size is NUM_CHANNELS × MEMORY_DEPTH × DATA_WIDTH.
- A beat is accepted when `s_axis_tvalid & s_axis_tready`.
- An accepted beat with `tdest` ≥ NUM_CHANNELS is consumed and discarded. No state changes.
- Accepted beat to channel c:
  - If `restart_pending[c]` is set, first set `wr_ptr`=0, `count`=0, `wrapped`=0, then write.
  - Write at `wr_ptr`, increment `wr_ptr` with modulo wrap, increment `count` with saturation.
  - If `count` was already MEMORY_DEPTH, set `wrapped[c]`.
- Continuous mode (FRAME_MODE=0):
  - `s_axis_tready` = 1 outside reset.
  - A tlast beat is stored, then `restart_pending[c]` is set. The completed packet stays readable until the next beat arrives on that channel.
- Frame mode (FRAME_MODE=1):
  - Channel states are CAPTURE and FROZEN.
  - CAPTURE→FROZEN on an accepted beat with tlast, or on the beat that makes `count` = MEMORY_DEPTH. A full channel never wraps.
  - FROZEN→CAPTURE on `release[c]`. This also sets `restart_pending[c]`.
  - `s_axis_tready` = !`frozen[tdest]`; it is 1 for an out-of-range tdest.
  - `release` on a channel in CAPTURE is ignored.
- Read path:
  - base = `wrapped` ? `wr_ptr` : 0.
  - Physical index = base + `rd_addr`, mod MEMORY_DEPTH.
  - `rd_data` = 0 when the index is invalid, otherwise RAM contents.
  - When `restart_pending` is set, reads still show the old packet.
- Reset (rst=0, asynchronous):
  - All pointers, counts, flags = 0; all channels in CAPTURE.
  - `rd_data`, `rd_valid`, `rd_count` = 0; `s_axis_tready` = 0 while asserted.
  - RAM contents are not cleared, but are unreadable because counts are 0.
  - Reset mid-frame discards the frame.

## Timing
- Write takes effect at the clock edge of acceptance.
- `count`, `frozen`, `wrapped` update on that same edge.
- Read latency is 1 cycle: `rd_chan`/`rd_addr` sampled at edge N produce `rd_data`/`rd_valid`/`rd_count` after edge N.
- Same-cycle read and write to the same physical entry returns the pre-write data (read-first). `rd_valid` and `rd_count` reflect the pre-write count.
- `s_axis_tready` is combinational from `tdest` and the registered `frozen`. No combinational path from `tvalid` or `tdata`.
- A freezing beat deasserts tready for that channel from the next cycle.
- A `release` at edge N makes tready 1 after N; a beat accepted at edge N+1 lands at index 0.

## Test plan
- Continuous, DEPTH=8: write 0..11 to ch1 without tlast → `wrapped[1]`=1, `rd_count`=8; `rd_addr` 0..7 read 4..11; `rd_valid`=1 throughout.
- Continuous: ch0 gets 3 beats 0xA,0xB,0xC with tlast on 0xC → reads 0xA,0xB,0xC; `rd_addr`=3 gives `rd_valid`=0, data 0. Next beat 0xD → `rd_count`=1, `rd_addr` 0 reads 0xD.
- Frame mode, DEPTH=8: 10 beats to ch2 → first 8 stored, `frozen[2]`=1, tready low for tdest=2; a tdest=3 beat is accepted the same cycle. After `release[2]` the next beat is stored at index 0.
- Interleaved tdest 0,1,0,1 with data 1..4 → ch0 holds 1,3 and ch1 holds 2,4; a tdest=NUM_CHANNELS beat alters neither channel.
- Read-first: read ch0 index at `wr_ptr` while writing it → old data returned; the next cycle returns new data.
- Assert rst mid-frame with ch1 frozen → immediately `frozen`=0, `wrapped`=0, tready=0; after deassert `rd_count`=0 for all channels and tready=1.

Source files
------------

// File: rtl/axis_capture_mem.sv
// Multi-channel AXI-stream circular capture buffer: beats are steered by tdest into
// per-channel regions of one shared RAM and read back by channel and age-relative index.
module axis_capture_mem #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int FRAME_MODE   = 0,
    localparam int AW = $clog2(MEMORY_DEPTH),
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tlast,
    input  logic [CW-1:0]           s_axis_tdest,
    input  logic [NUM_CHANNELS-1:0] release_req,
    input  logic [CW-1:0]           rd_chan,
    input  logic [AW-1:0]           rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic [AW:0]             rd_count,
    output logic [NUM_CHANNELS-1:0] frozen,
    output logic [NUM_CHANNELS-1:0] wrapped
);

    localparam int RAW = $clog2(NUM_CHANNELS * MEMORY_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(MEMORY_DEPTH);
    localparam logic [CW:0] NC_W = (CW + 1)'(NUM_CHANNELS);

    logic [DATA_WIDTH-1:0] mem [NUM_CHANNELS * MEMORY_DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;

    logic [AW-1:0] chan_ptr      [NUM_CHANNELS];
    logic [AW-1:0] chan_ptr_base [NUM_CHANNELS];
    logic [AW:0]   chan_count    [NUM_CHANNELS];

    logic          dest_in_range;
    logic          dest_frozen;
    logic [AW-1:0] wr_ptr_sel;
    logic          beat_ok;
    logic [RAW-1:0] wr_ram_addr;

    logic          rd_in_range;
    logic [AW:0]   sel_count;
    logic [AW-1:0] sel_ptr;
    logic          sel_wrapped;
    logic [AW-1:0] rd_phys;
    logic [RAW-1:0] rd_ram_addr;
    logic          rd_valid_next;
    logic          rd_valid_reg;
    logic [AW:0]   rd_count_reg;

    assign dest_in_range = ({1'b0, s_axis_tdest} < NC_W);
    assign rd_in_range   = ({1'b0, rd_chan} < NC_W);

    always_comb begin
        dest_frozen = 1'b0;
        wr_ptr_sel  = '0;
        sel_count   = '0;
        sel_ptr     = '0;
        sel_wrapped = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (s_axis_tdest == CW'(c)) begin
                dest_frozen = frozen[c];
                wr_ptr_sel  = chan_ptr_base[c];
            end
            if (rd_chan == CW'(c)) begin
                sel_count   = chan_count[c];
                sel_ptr     = chan_ptr[c];
                sel_wrapped = wrapped[c];
            end
        end
    end

    // Out-of-range destinations are always accepted so they can be drained and dropped.
    assign s_axis_tready = rst & ((FRAME_MODE != 0) ? (!dest_in_range || !dest_frozen) : 1'b1);
    assign beat_ok       = s_axis_tvalid & s_axis_tready & dest_in_range;
    assign wr_ram_addr   = RAW'({s_axis_tdest, wr_ptr_sel});

    assign rd_phys       = (sel_wrapped ? sel_ptr : '0) + rd_addr;
    assign rd_ram_addr   = rd_in_range ? RAW'({rd_chan, rd_phys}) : '0;
    assign rd_valid_next = ({1'b0, rd_addr} < sel_count);

    // Shared RAM, read-first: a same-cycle read of the written entry returns old data.
    always_ff @(posedge clk) begin
        if (beat_ok) begin
            mem[wr_ram_addr] <= s_axis_tdata;
        end
        ram_q <= mem[rd_ram_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_reg <= 1'b0;
            rd_count_reg <= '0;
        end else begin
            rd_valid_reg <= rd_valid_next;
            rd_count_reg <= sel_count;
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_count = rd_count_reg;
    assign rd_data  = rd_valid_reg ? ram_q : '0;

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
        logic [AW-1:0] ptr_reg;
        logic [AW:0]   count_reg;
        logic          restart_reg;
        logic          frozen_reg;
        logic          wrapped_reg;
        logic [AW-1:0] ptr_base;
        logic [AW:0]   count_base;
        logic          wrapped_base;
        logic          hit;

        assign hit          = beat_ok && (s_axis_tdest == CW'(gi));
        // A pending restart makes the next beat start a fresh packet at index 0.
        assign ptr_base     = restart_reg ? '0 : ptr_reg;
        assign count_base   = restart_reg ? '0 : count_reg;
        assign wrapped_base = restart_reg ? 1'b0 : wrapped_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ptr_reg     <= '0;
                count_reg   <= '0;
                restart_reg <= 1'b0;
                frozen_reg  <= 1'b0;
                wrapped_reg <= 1'b0;
            end else if (hit) begin
                ptr_reg     <= ptr_base + AW'(1);
                count_reg   <= (count_base == FULL) ? FULL : count_base + (AW + 1)'(1);
                wrapped_reg <= wrapped_base | (count_base == FULL);
                if (FRAME_MODE != 0) begin
                    restart_reg <= 1'b0;
                    frozen_reg  <= s_axis_tlast | ((count_base + (AW + 1)'(1)) == FULL);
                end else begin
                    restart_reg <= s_axis_tlast;
                end
            end else if ((FRAME_MODE != 0) && frozen_reg && release_req[gi]) begin
                frozen_reg  <= 1'b0;
                restart_reg <= 1'b1;
            end
        end

        assign chan_ptr[gi]      = ptr_reg;
        assign chan_ptr_base[gi] = ptr_base;
        assign chan_count[gi]    = count_reg;
        assign frozen[gi]        = frozen_reg;
        assign wrapped[gi]       = wrapped_reg;
    end

endmodule

// File: tb/tb_axis_capture_mem.sv
// Drives one stimulus stream into a continuous and a freeze-on-frame instance and
// checks both against per-channel queue models of stored samples.
module tb_axis_capture_mem;

    localparam int DW = 32;
    localparam int D  = 8;
    localparam int NC = 3;
    localparam int AW = 3;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          tvalid  = 1'b0;
    logic [DW-1:0] tdata   = '0;
    logic          tlast   = 1'b0;
    logic [CW-1:0] tdest   = '0;
    logic [NC-1:0] rel     = '0;
    logic [CW-1:0] rd_chan = '0;
    logic [AW-1:0] rd_addr = '0;

    logic          c_ready, f_ready;
    logic [DW-1:0] c_rd_data, f_rd_data;
    logic          c_rd_valid, f_rd_valid;
    logic [AW:0]   c_rd_count, f_rd_count;
    logic [NC-1:0] c_frozen, f_frozen_o, c_wrapped, f_wrapped;

    axis_capture_mem #(.DATA_WIDTH(DW), .MEMORY_DEPTH(D), .NUM_CHANNELS(NC), .FRAME_MODE(0)) u_cont (
        .clk(clk), .rst(rst), .s_axis_tvalid(tvalid), .s_axis_tready(c_ready),
        .s_axis_tdata(tdata), .s_axis_tlast(tlast), .s_axis_tdest(tdest), .release_req(rel),
        .rd_chan(rd_chan), .rd_addr(rd_addr), .rd_data(c_rd_data), .rd_valid(c_rd_valid),
        .rd_count(c_rd_count), .frozen(c_frozen), .wrapped(c_wrapped));

    axis_capture_mem #(.DATA_WIDTH(DW), .MEMORY_DEPTH(D), .NUM_CHANNELS(NC), .FRAME_MODE(1)) u_frame (
        .clk(clk), .rst(rst), .s_axis_tvalid(tvalid), .s_axis_tready(f_ready),
        .s_axis_tdata(tdata), .s_axis_tlast(tlast), .s_axis_tdest(tdest), .release_req(rel),
        .rd_chan(rd_chan), .rd_addr(rd_addr), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .rd_count(f_rd_count), .frozen(f_frozen_o), .wrapped(f_wrapped));

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Model: each channel is a list of stored samples, oldest first.
    logic [DW-1:0] cq [NC][$];
    logic [DW-1:0] fq [NC][$];
    bit c_restart [NC];
    bit c_wrap    [NC];
    bit f_frozen  [NC];
    bit f_restart [NC];

    function automatic int m_count(bit fm, int ch);
        if (ch >= NC) return 0;
        return fm ? fq[ch].size() : cq[ch].size();
    endfunction

    function automatic logic [DW-1:0] m_data(bit fm, int ch, int a);
        if (a >= m_count(fm, ch)) return '0;
        return fm ? fq[ch][a] : cq[ch][a];
    endfunction

    function automatic bit m_ready(bit fm, int d);
        if (!fm || d >= NC) return 1'b1;
        return !f_frozen[d];
    endfunction

    function automatic logic [NC-1:0] m_frozen_vec();
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = f_frozen[c];
        return v;
    endfunction

    function automatic logic [NC-1:0] m_wrap_vec();
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = c_wrap[c];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            cq[c].delete();
            fq[c].delete();
            c_restart[c] = 0;
            c_wrap[c]    = 0;
            f_frozen[c]  = 0;
            f_restart[c] = 0;
        end
    endtask

    task automatic model_edge();
        bit pre_f [NC];
        int d;
        for (int c = 0; c < NC; c++) pre_f[c] = f_frozen[c];
        d = int'(tdest);
        if (tvalid && d < NC) begin
            if (c_restart[d]) begin
                cq[d].delete();
                c_wrap[d]    = 0;
                c_restart[d] = 0;
            end
            cq[d].push_back(tdata);
            if (cq[d].size() > D) begin
                cq[d].delete(0);
                c_wrap[d] = 1;
            end
            if (tlast) c_restart[d] = 1;
            if (!pre_f[d]) begin
                if (f_restart[d]) begin
                    fq[d].delete();
                    f_restart[d] = 0;
                end
                fq[d].push_back(tdata);
                if (tlast || fq[d].size() == D) f_frozen[d] = 1;
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (rel[c] && pre_f[c]) begin
                f_frozen[c]  = 0;
                f_restart[c] = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (tvalid || rel != 0)
            $display("txn %0d: valid=%0b dest=%0d data=%h last=%0b release=%b", txn, tvalid, tdest, tdata, tlast, rel);
        txn++;
        model_edge();
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        rel    = '0;
    endtask

    task automatic drive(input logic [CW-1:0] d, input logic [DW-1:0] v, input logic l);
        tvalid = 1'b1;
        tdest  = d;
        tdata  = v;
        tlast  = l;
    endtask

    task automatic set_rd(input int ch, input int a);
        rd_chan = CW'(ch);
        rd_addr = AW'(a);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({c_ready, c_rd_valid, c_rd_count, c_frozen, c_wrapped, c_rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_cont: ready=%0b valid=%0b count=%0d frozen=%b wrapped=%b data=%h, need all 0",
                     c_ready, c_rd_valid, c_rd_count, c_frozen, c_wrapped, c_rd_data);
        end
        checks++;
        if ({f_ready, f_rd_valid, f_rd_count, f_frozen_o, f_wrapped, f_rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_frame: ready=%0b valid=%0b count=%0d frozen=%b wrapped=%b data=%h, need all 0",
                     f_ready, f_rd_valid, f_rd_count, f_frozen_o, f_wrapped, f_rd_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (c_ready !== 1'b1 || f_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: cont=%0b frame=%0b, need 1/1", c_ready, f_ready);
        end
    endtask

    task automatic test_cont_wrap();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(2'd1, DW'(i), 1'b0);
            tick();
        end
        checks++;
        if (c_wrapped !== 3'b010 || c_wrapped !== m_wrap_vec()) begin
            errors++;
            $display("FAIL wrap_flag: wrapped=%b, need %b", c_wrapped, m_wrap_vec());
        end
        checks++;
        if (f_frozen_o !== 3'b010 || f_wrapped !== 3'b000) begin
            errors++;
            $display("FAIL wrap_frame_full: frozen=%b wrapped=%b, need 010/000", f_frozen_o, f_wrapped);
        end
        for (int a = 0; a < D; a++) begin
            set_rd(1, a);
            tick();
            checks++;
            if (c_rd_data !== DW'(4 + a) || c_rd_valid !== 1'b1 || c_rd_count !== 4'd8) begin
                errors++;
                $display("FAIL wrap_read a=%0d: data=%h valid=%0b count=%0d, need %h 1 8",
                         a, c_rd_data, c_rd_valid, c_rd_count, 4 + a);
            end
            checks++;
            if (f_rd_data !== m_data(1, 1, a) || f_rd_count !== 4'(m_count(1, 1))) begin
                errors++;
                $display("FAIL wrap_frame_read a=%0d: data=%h count=%0d, need %h %0d",
                         a, f_rd_data, f_rd_count, m_data(1, 1, a), m_count(1, 1));
            end
        end
    endtask

    task automatic test_cont_packet();
        logic [DW-1:0] exp_d;
        do_reset();
        drive(2'd0, 32'hA, 1'b0); tick();
        drive(2'd0, 32'hB, 1'b0); tick();
        drive(2'd0, 32'hC, 1'b1); tick();
        for (int a = 0; a < 4; a++) begin
            set_rd(0, a);
            tick();
            exp_d = (a < 3) ? DW'(32'hA + a) : '0;
            checks++;
            if (c_rd_data !== exp_d || c_rd_valid !== (a < 3) || c_rd_count !== 4'd3) begin
                errors++;
                $display("FAIL packet_read a=%0d: data=%h valid=%0b count=%0d, need %h %0b 3",
                         a, c_rd_data, c_rd_valid, c_rd_count, exp_d, a < 3);
            end
        end
        drive(2'd0, 32'hD, 1'b0);
        #1;
        checks++;
        if (c_ready !== 1'b1 || f_ready !== 1'b0) begin
            errors++;
            $display("FAIL packet_ready: cont=%0b frame=%0b, need 1/0", c_ready, f_ready);
        end
        set_rd(0, 0);
        tick();
        tick();
        checks++;
        if (c_rd_data !== 32'hD || c_rd_count !== 4'd1 || c_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL packet_restart: data=%h count=%0d valid=%0b, need d 1 1", c_rd_data, c_rd_count, c_rd_valid);
        end
        checks++;
        if (f_rd_data !== 32'hA || f_rd_count !== 4'd3) begin
            errors++;
            $display("FAIL packet_frame_held: data=%h count=%0d, need a 3", f_rd_data, f_rd_count);
        end
    endtask

    task automatic test_frame_freeze();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(2'd2, DW'(32'h20 + i), 1'b0);
            #1;
            checks++;
            if (f_ready !== (i < 8)) begin
                errors++;
                $display("FAIL freeze_ready beat=%0d: ready=%0b, need %0b", i, f_ready, i < 8);
            end
            tick();
        end
        drive(2'd3, 32'h99, 1'b0);
        #1;
        checks++;
        if (f_ready !== 1'b1) begin
            errors++;
            $display("FAIL freeze_oor_ready: ready=%0b, need 1", f_ready);
        end
        tick();
        for (int a = 0; a < D; a++) begin
            set_rd(2, a);
            tick();
            checks++;
            if (f_rd_data !== DW'(32'h20 + a) || f_rd_count !== 4'd8 || f_frozen_o !== 3'b100) begin
                errors++;
                $display("FAIL freeze_read a=%0d: data=%h count=%0d frozen=%b, need %h 8 100",
                         a, f_rd_data, f_rd_count, f_frozen_o, 32'h20 + a);
            end
        end
        rel = 3'b100;
        tick();
        tdest = 2'd2;
        set_rd(2, 0);
        #1;
        checks++;
        if (f_frozen_o !== 3'b000 || f_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: frozen=%b ready=%0b, need 000 1", f_frozen_o, f_ready);
        end
        tick();
        checks++;
        if (f_rd_count !== 4'd8 || f_rd_data !== 32'h20) begin
            errors++;
            $display("FAIL release_old_visible: count=%0d data=%h, need 8 20", f_rd_count, f_rd_data);
        end
        drive(2'd2, 32'h55, 1'b0);
        tick();
        tick();
        checks++;
        if (f_rd_data !== 32'h55 || f_rd_count !== 4'd1) begin
            errors++;
            $display("FAIL release_index0: data=%h count=%0d, need 55 1", f_rd_data, f_rd_count);
        end
        rel = 3'b100;
        tick();
        drive(2'd2, 32'h56, 1'b0);
        tick();
        set_rd(2, 1);
        tick();
        checks++;
        if (f_rd_data !== 32'h56 || f_rd_count !== 4'd2) begin
            errors++;
            $display("FAIL release_in_capture: data=%h count=%0d, need 56 2", f_rd_data, f_rd_count);
        end
    endtask

    task automatic test_interleave();
        logic [DW-1:0] exp_d;
        do_reset();
        drive(2'd0, 32'd1, 1'b0); tick();
        drive(2'd1, 32'd2, 1'b0); tick();
        drive(2'd0, 32'd3, 1'b0); tick();
        drive(2'd1, 32'd4, 1'b0); tick();
        drive(2'd3, 32'h99, 1'b1); tick();
        for (int k = 0; k < 4; k++) begin
            set_rd(k / 2, k % 2);
            tick();
            exp_d = DW'(1 + (k / 2) + 2 * (k % 2));
            checks++;
            if (c_rd_data !== exp_d || c_rd_count !== 4'd2 || f_rd_data !== exp_d || f_rd_count !== 4'd2) begin
                errors++;
                $display("FAIL interleave ch=%0d a=%0d: cont=%h/%0d frame=%h/%0d, need %h/2",
                         k / 2, k % 2, c_rd_data, c_rd_count, f_rd_data, f_rd_count, exp_d);
            end
        end
        set_rd(3, 0);
        tick();
        checks++;
        if (c_rd_valid !== 1'b0 || c_rd_count !== 4'd0 || c_rd_data !== '0) begin
            errors++;
            $display("FAIL read_oor_chan: valid=%0b count=%0d data=%h, need 0 0 0", c_rd_valid, c_rd_count, c_rd_data);
        end
    endtask

    task automatic test_read_first();
        do_reset();
        for (int i = 0; i < D; i++) begin
            drive(2'd0, DW'(32'h100 + i), 1'b0);
            tick();
        end
        set_rd(0, 0);
        drive(2'd0, 32'h200, 1'b0);
        tick();
        checks++;
        if (c_rd_data !== 32'h100 || c_rd_count !== 4'd8 || c_wrapped[0] !== 1'b1) begin
            errors++;
            $display("FAIL read_first_old: data=%h count=%0d wrapped=%0b, need 100 8 1", c_rd_data, c_rd_count, c_wrapped[0]);
        end
        set_rd(0, 7);
        tick();
        checks++;
        if (c_rd_data !== 32'h200) begin
            errors++;
            $display("FAIL read_first_new: data=%h, need 200", c_rd_data);
        end
        checks++;
        if (f_rd_data !== m_data(1, 0, 7) || f_rd_data !== 32'h107) begin
            errors++;
            $display("FAIL read_first_frame: data=%h, need 107", f_rd_data);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] ecd, efd;
        bit ecv, efv, ecr, efr;
        int ecc, efc, ch, a;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            tvalid = ($urandom_range(0, 3) != 0);
            tdest  = CW'($urandom_range(0, 3));
            tdata  = $urandom;
            tlast  = ($urandom_range(0, 7) == 0);
            rel    = ($urandom_range(0, 5) == 0) ? NC'($urandom_range(0, 7)) : '0;
            ch     = $urandom_range(0, 3);
            a      = $urandom_range(0, D - 1);
            set_rd(ch, a);
            ecd = m_data(0, ch, a); ecv = a < m_count(0, ch); ecc = m_count(0, ch);
            efd = m_data(1, ch, a); efv = a < m_count(1, ch); efc = m_count(1, ch);
            ecr = m_ready(0, int'(tdest)); efr = m_ready(1, int'(tdest));
            #1;
            checks++;
            if (c_ready !== ecr || f_ready !== efr) begin
                errors++;
                $display("FAIL rand_ready n=%0d: cont=%0b frame=%0b, need %0b %0b", n, c_ready, f_ready, ecr, efr);
            end
            tick();
            checks++;
            if (c_rd_data !== ecd || c_rd_valid !== ecv || c_rd_count !== 4'(ecc)) begin
                errors++;
                $display("FAIL rand_cont n=%0d ch=%0d a=%0d: %h/%0b/%0d, need %h/%0b/%0d",
                         n, ch, a, c_rd_data, c_rd_valid, c_rd_count, ecd, ecv, ecc);
            end
            checks++;
            if (f_rd_data !== efd || f_rd_valid !== efv || f_rd_count !== 4'(efc)) begin
                errors++;
                $display("FAIL rand_frame n=%0d ch=%0d a=%0d: %h/%0b/%0d, need %h/%0b/%0d",
                         n, ch, a, f_rd_data, f_rd_valid, f_rd_count, efd, efv, efc);
            end
            checks++;
            if (c_wrapped !== m_wrap_vec() || f_frozen_o !== m_frozen_vec() || f_wrapped !== '0 || c_frozen !== '0) begin
                errors++;
                $display("FAIL rand_flags n=%0d: cwrap=%b ffrozen=%b fwrap=%b cfrozen=%b, need %b %b 000 000",
                         n, c_wrapped, f_frozen_o, f_wrapped, c_frozen, m_wrap_vec(), m_frozen_vec());
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(2'd1, DW'(32'h300 + i), 1'b0);
            tick();
        end
        checks++;
        if (f_frozen_o !== 3'b010 || c_wrapped !== 3'b010) begin
            errors++;
            $display("FAIL midreset_pre: frozen=%b wrapped=%b, need 010 010", f_frozen_o, c_wrapped);
        end
        tdest = 2'd1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (f_frozen_o !== '0 || c_wrapped !== '0 || c_ready !== 1'b0 || f_ready !== 1'b0 || c_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: frozen=%b wrapped=%b ready=%0b/%0b valid=%0b, need 000 000 0/0 0",
                     f_frozen_o, c_wrapped, c_ready, f_ready, c_rd_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (c_ready !== 1'b1 || f_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: cont=%0b frame=%0b, need 1/1", c_ready, f_ready);
        end
        for (int c = 0; c < NC; c++) begin
            set_rd(c, 0);
            tick();
            checks++;
            if (c_rd_count !== 4'd0 || f_rd_count !== 4'd0 || c_rd_valid !== 1'b0 || f_rd_data !== '0) begin
                errors++;
                $display("FAIL midreset_count ch=%0d: cont=%0d frame=%0d valid=%0b data=%h, need 0 0 0 0",
                         c, c_rd_count, f_rd_count, c_rd_valid, f_rd_data);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cont_wrap();
        test_cont_packet();
        test_frame_freeze();
        test_interleave();
        test_read_first();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
